md_unit: RTL and testbench

//  Multi-cycle multiply/divide unit with architectural HI/LO registers, placed in EX beside the ALU.

---
 rtl/md_pkg.sv | 32 +++
 rtl/md_arith.sv | 53 +++++
 rtl/md_unit.sv | 109 ++++++++++
 tb/tb_md_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared opcode encoding and FSM state types for the multiply/divide unit.
// The stall unit and the control unit decode md_op with these same values.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Operations that occupy the unit for a multi-cycle latency.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Results are only meaningful for
// MULT/MULTU/DIV/DIVU; the caller decides whether and when to commit them.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic             sgn;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] div_b;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    always_comb begin
        sgn = is_signed_op(op);

        // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
        ext_a = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = ext_a * ext_b;

        // Signed division on magnitudes; MIN_INT/-1 falls out as MIN_INT with zero remainder.
        mag_a = (sgn && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
        mag_b = (sgn && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
        div_b = (mag_b == '0) ? WIDTH'(1) : mag_b;
        q_mag = mag_a / div_b;
        r_mag = mag_a % div_b;
        quot  = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? (WIDTH'(0) - q_mag) : q_mag;
        rem   = (sgn && a[WIDTH-1]) ? (WIDTH'(0) - r_mag) : r_mag;

        if (is_div_op(op)) begin
            res_hi = rem;
            res_lo = quot;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Long ops latch operands, hold busy for their latency, then commit HI/LO as busy falls.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    md_state_e        state;
    md_state_e        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             accept;
    logic             commit;
    logic             div_zero;
    logic             hi_we;
    logic             lo_we;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Handshake: start qualifies md_op for one cycle and is only honoured while busy is low;
    // the stall unit holds md-class instructions while start|busy, so start during busy is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                op_q <= md_op;
                a_q  <= a;
                b_q  <= b;
            end
            if (commit && !div_zero) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (hi_we) hi <= a;
            if (lo_we) lo <= a;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_RUN;
                    cnt_next   = is_div_op(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state == ST_RUN);
        accept   = (state == ST_IDLE) && start && is_long_op(md_op);
        hi_we    = (state == ST_IDLE) && start && (md_op == MD_MTHI);
        lo_we    = (state == ST_IDLE) && start && (md_op == MD_MTLO);
        commit   = (state == ST_RUN) && (cnt == CNT_W'(1));
        div_zero = is_div_op(op_q) && (b_q == '0);
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops against a
// 64-bit arithmetic reference model of HI/LO and busy timing.
module tb_md_unit;

    localparam int W       = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   md_op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    md_unit #(.WIDTH(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int lat_of(input logic [2:0] op);
        if (op == OP_MULT || op == OP_MULTU) return MUL_LAT;
        if (op == OP_DIV || op == OP_DIVU) return DIV_LAT;
        return 0;
    endfunction

    task automatic model_apply(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint      sp;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] up;
        logic [63:0] uq;
        logic [63:0] ur;
        case (op)
            OP_MULT: begin
                sp = longint'($signed(av)) * longint'($signed(bv));
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            OP_MULTU: begin
                up = {32'b0, av} * {32'b0, bv};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            OP_DIV: if (bv != 0) begin
                sa = longint'($signed(av));
                sb = longint'($signed(bv));
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            OP_DIVU: if (bv != 0) begin
                uq = {32'b0, av} / {32'b0, bv};
                ur = {32'b0, av} % {32'b0, bv};
                m_lo = uq[31:0];
                m_hi = ur[31:0];
            end
            OP_MTHI: m_hi = av;
            OP_MTLO: m_lo = av;
            default: ;
        endcase
    endtask

    // ---------------- driver: one op, full timing + result check ----------------
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] old_hi;
        logic [W-1:0] old_lo;
        logic [W-1:0] e;
        int           lat;
        old_hi = m_hi;
        old_lo = m_lo;
        lat = lat_of(op);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_before_start op=%0d: busy=%b expected 0", op, busy);
        end
        start = 1'b1; md_op = op; a = av; b = bv;
        tick();
        start = 1'b0; md_op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        for (int i = 0; i < lat; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || hi !== old_hi || lo !== old_lo) begin
                n_bad++;
                $display("FAIL busy_hold op=%0d cyc=%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                         op, i + 1, busy, hi, lo, old_hi, old_lo);
            end
            tick();
        end
        model_apply(op, av, bv);
        exp_q.push_back(m_hi);
        exp_q.push_back(m_lo);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_fall op=%0d: busy=%b expected 0", op, busy);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (hi !== e) begin
            n_bad++;
            $display("FAIL hi_result op=%0d a=%h b=%h: hi=%h expected %h", op, av, bv, hi, e);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (lo !== e) begin
            n_bad++;
            $display("FAIL lo_result op=%0d a=%h b=%h: lo=%h expected %h", op, av, bv, lo, e);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
    endtask

    task automatic test_mult();
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        n_cmp++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            n_bad++;
            $display("FAIL mult_neg3x7: hi=%h lo=%h expected ffffffff ffffffeb", hi, lo);
        end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        n_cmp++;
        if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
            n_bad++;
            $display("FAIL multu_max_x2: hi=%h lo=%h expected 00000001 fffffffe", hi, lo);
        end
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_div();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        n_cmp++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_bad++;
            $display("FAIL div_neg7_by2: hi=%h lo=%h expected ffffffff fffffffd", hi, lo);
        end
        run_op(OP_DIVU, 32'd7, 32'd2);
        n_cmp++;
        if (hi !== 32'd1 || lo !== 32'd3) begin
            n_bad++;
            $display("FAIL divu_7_by2: hi=%h lo=%h expected 00000001 00000003", hi, lo);
        end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL div_min_by_neg1: hi=%h lo=%h expected 00000000 80000000", hi, lo);
        end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_div_zero();
        run_op(OP_MTHI, 32'h1234, 32'h0);
        run_op(OP_MTLO, 32'h5678, 32'h0);
        run_op(OP_DIV, 32'd99, 32'd0);
        n_cmp++;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin
            n_bad++;
            $display("FAIL div_by_zero_keep: hi=%h lo=%h expected 00001234 00005678", hi, lo);
        end
        run_op(OP_DIVU, 32'd5, 32'd0);
    endtask

    task automatic test_undefined_op();
        run_op(3'd6, 32'hDEAD_BEEF, 32'd3);
        run_op(3'd7, 32'hCAFE_F00D, 32'd9);
    endtask

    task automatic test_start_while_busy();
        logic [W-1:0] old_hi;
        logic [W-1:0] old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        start = 1'b1; md_op = OP_MULT; a = 32'd1000; b = 32'hFFFF_FFF6;
        tick();
        start = 1'b0;
        for (int i = 1; i <= MUL_LAT; i++) begin
            if (i == 2) begin
                start = 1'b1; md_op = OP_DIV; a = 32'd77; b = 32'd5;
            end else begin
                start = 1'b0;
            end
            n_cmp++;
            if (busy !== 1'b1 || hi !== old_hi || lo !== old_lo) begin
                n_bad++;
                $display("FAIL busy_ignore_hold cyc=%0d: busy=%b hi=%h lo=%h expected 1 %h %h",
                         i, busy, hi, lo, old_hi, old_lo);
            end
            tick();
        end
        start = 1'b0;
        model_apply(OP_MULT, 32'd1000, 32'hFFFF_FFF6);
        n_cmp++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_bad++;
            $display("FAIL busy_ignore_commit: busy=%b hi=%h lo=%h expected 0 %h %h", busy, hi, lo, m_hi, m_lo);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_bad++;
            $display("FAIL busy_ignore_no_div: busy=%b hi=%h lo=%h expected 0 %h %h", busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; md_op = OP_DIV; a = 32'd1000; b = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL midrst_busy cyc=%0d: busy=%b expected 1", i, busy);
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        n_cmp++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_bad++;
            $display("FAIL midrst_abort: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
        for (int i = 0; i < DIV_LAT; i++) begin
            n_cmp++;
            if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
                n_bad++;
                $display("FAIL midrst_discard cyc=%0d: busy=%b hi=%h lo=%h expected 0 0 0", i, busy, hi, lo);
            end
            tick();
        end
        run_op(OP_MTLO, 32'd5, 32'd0);
        n_cmp++;
        if (lo !== 32'd5) begin
            n_bad++;
            $display("FAIL midrst_mtlo: lo=%h expected 00000005", lo);
        end
    endtask

    task automatic test_back_to_back();
        run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd10);
        run_op(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
        run_op(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_op(OP_MTLO, 32'h0F0F_0F0F, 32'd0);
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            run_op(op, pick_val(), pick_val());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_undefined_op();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
